run_done_ctrl: RTL

//  Return half of the testbench run handshake. Start (level from the testbench) launches a

---
 rtl/run_done_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/run_done_ctrl.sv
// Run/done handshake: gates the PC enable during a program run, counts executed cycles,
// and reports completion by halt or by timeout after an optional writeback drain.
module run_done_ctrl #(
    parameter int unsigned      CYC_W     = 16,
    parameter logic [CYC_W-1:0] TIMEOUT   = 16'hFFFF,
    parameter int unsigned      DRAIN_CYC = 2
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Halt,
    output logic             CountEn,
    output logic             Done,
    output logic             TimedOut,
    output logic [CYC_W-1:0] CycleCount
);

    localparam int unsigned     DW         = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0]   DRAIN_LAST = DW'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam state_t STOP_STATE = (DRAIN_CYC == 0) ? S_DONE : S_DRAIN;

    state_t           state_q, state_d;
    logic [CYC_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic             at_limit;

    assign at_limit   = (cnt_q == TIMEOUT);
    assign TimedOut   = to_q;
    assign CycleCount = cnt_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            to_q    <= 1'b0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        drain_d = drain_q;
        CountEn = 1'b0;
        Done    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (Start) state_d = S_HOLD;
            end

            S_HOLD: begin
                cnt_d = '0;
                to_d  = 1'b0;
                if (!Start) state_d = S_RUN;
            end

            S_RUN: begin
                CountEn = ~Start & ~Halt & ~at_limit;
                // Abort outranks halt, and halt outranks timeout, so TimedOut only
                // rises when the limit is reached without a halt in the same cycle.
                if (Start) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    to_d    = 1'b0;
                end else if (Halt) begin
                    state_d = STOP_STATE;
                    drain_d = '0;
                    to_d    = 1'b0;
                end else if (at_limit) begin
                    state_d = STOP_STATE;
                    drain_d = '0;
                    to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DRAIN: begin
                if (Start) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    to_d    = 1'b0;
                end else if (drain_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end

            S_DONE: begin
                Done = 1'b1;
                if (Start) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    to_d    = 1'b0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule
